devil_snoop_scheduler: RTL and testbench
========================================

DEVIL_SNOOP_SCHEDULER -- requirements
Module: devil_snoop_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- C_S_AXI_DATA_WIDTH, 32, control/status register width.
- C_ACE_ADDR_WIDTH, 44, snoop address width.
- FIFO_DEPTH, 4, snoop request queue entries (power of two).
- TIMEOUT_CYCLES, 1024, engine response wait limit.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- ace_aclk, in, 1, clock.
- ace_areset, in, 1, asynchronous active-high reset.
- acvalid, in, 1, snoop request valid.
- acready, out, 1, snoop request accepted.
- acaddr, in, C_ACE_ADDR_WIDTH, snoop address.
- acsnoop, in, 4, snoop type.
- crvalid, out, 1, snoop response valid.
- crready, in, 1, snoop response accepted.
- crresp, out, 5, snoop response.
- eng_start, out, 1, one-cycle dispatch pulse to the response engine.
- eng_acaddr, out, C_ACE_ADDR_WIDTH, dispatched address.
- eng_acsnoop, out, 4, dispatched snoop type.
- eng_done, in, 1, engine completion pulse.
- eng_crresp, in, 5, engine response, valid with eng_done.
- i_control_reg, in, C_S_AXI_DATA_WIDTH, [0] enable, [1] bypass, [6:2] default crresp.
- o_status_reg, out, C_S_AXI_DATA_WIDTH, [2:0] FIFO level, [3] busy, [4] timeout sticky, [31:16] serviced count.

Function
REQ-004 The block SHALL accept a snoop into the FIFO when acvalid and acready are both 1 at a clock edge.

REQ-005 acready SHALL be 1 exactly when the registered FIFO level is below FIFO_DEPTH.

REQ-006 When a push and a pop occur in the same cycle, the FIFO level SHALL be unchanged; a full FIFO SHALL NOT accept a push.

REQ-007 The state machine SHALL have four states: SCH_IDLE, SCH_DISPATCH, SCH_WAIT and SCH_RESP.

REQ-008 In SCH_IDLE with the FIFO not empty, the next state SHALL be:
- SCH_DISPATCH if enable=1 and bypass=0;
- otherwise SCH_RESP, with the response latched from default crresp.

REQ-009 SCH_DISPATCH SHALL:
- drive eng_start=1 for exactly one cycle;
- drive eng_acaddr and eng_acsnoop from the FIFO head;
- go to SCH_WAIT.

REQ-010 In SCH_WAIT, eng_done=1 SHALL latch eng_crresp and move to SCH_RESP on the next edge.

REQ-011 The wait counter SHALL clear on entry to SCH_WAIT. When it reaches TIMEOUT_CYCLES-1 without eng_done, the block SHALL:
- latch default crresp;
- set timeout sticky;
- go to SCH_RESP.
If eng_done and timeout coincide, eng_done SHALL win.

REQ-012 In SCH_RESP, crvalid SHALL be 1 and crresp SHALL be held stable until crready=1.

REQ-013 On the crvalid/crready handshake, the block SHALL:
- pop the FIFO head;
- increment the serviced count (16-bit, wraps 0xFFFF to 0x0000);
- return to SCH_IDLE.

REQ-014 eng_done outside SCH_WAIT SHALL be ignored.

REQ-015 Snoops SHALL be responded to strictly in acceptance order.

REQ-016 Minimum latency from acceptance into an empty FIFO to crvalid SHALL be:
- 2 cycles in the bypass path;
- 4 cycles in the engine path when eng_done arrives on the cycle after eng_start.

REQ-017 busy SHALL be 1 whenever the state is not SCH_IDLE.

REQ-018 Timeout sticky SHALL clear when i_control_reg[0] is 0.

REQ-019 Changes to enable or bypass SHALL take effect only at the next SCH_IDLE decision; an in-flight snoop SHALL complete on its current path.

Reset
REQ-020 While ace_areset=1, the block SHALL hold these reset values:
- state SCH_IDLE;
- FIFO empty;
- acready=1;
- crvalid=0, crresp=0;
- eng_start=0, eng_acaddr=0, eng_acsnoop=0;
- o_status_reg=0.

REQ-021 Reset asserted mid-operation SHALL discard all queued and in-flight snoops, and no response SHALL be issued for them after release.

Configuration
REQ-022 With macro DEVIL_SCHED_TIMEOUT_EN defined, SCH_WAIT SHALL implement the REQ-011 timeout.

REQ-023 Without DEVIL_SCHED_TIMEOUT_EN, SCH_WAIT SHALL wait for eng_done indefinitely, no wait counter SHALL exist, and o_status_reg[4] SHALL read 0.

Verification
REQ-024 Bypass path: bypass=1, default crresp=0x05, one snoop -> crvalid after 2 cycles with crresp=0x05, no eng_start, count=1.

REQ-025 Engine path: enable=1, snoop at acaddr=0x1000, engine returns eng_crresp=0x11 three cycles after eng_start -> single eng_start with eng_acaddr=0x1000, then crresp=0x11.

REQ-026 Backpressure: crready=0, five back-to-back snoops -> acready=0 after four accepted, level=4; release crready -> four responses in order.

REQ-027 Timeout (macro defined): engine never responds, TIMEOUT_CYCLES=16 -> crresp=default 16 cycles after SCH_WAIT entry, status[4]=1; enable=0 clears it.

REQ-028 Reset mid-SCH_WAIT: assert ace_areset for 1 cycle -> all outputs at reset values; a late eng_done produces no crvalid.

REQ-029 Wrap: preload 65535 serviced snoops (or force count) then one more -> status[31:16]=0x0000.

Source files
------------

// File: rtl/devil_snoop_scheduler.sv
// rtl/devil_snoop_scheduler.sv - ACE snoop request queue with engine dispatch and ordered responses
// Optional feature macro: DEVIL_SCHED_TIMEOUT_EN (engine response timeout in SCH_WAIT).
// Ports:
//   ace_aclk / ace_areset          clock, asynchronous active-high reset
//   acvalid/acready/acaddr/acsnoop snoop request channel into the queue
//   crvalid/crready/crresp         snoop response channel, strictly in acceptance order
//   eng_start/eng_acaddr/eng_acsnoop  one-cycle dispatch of the queue head to the engine
//   eng_done/eng_crresp            engine completion and its response
//   i_control_reg                  [0] enable, [1] bypass, [6:2] default crresp
//   o_status_reg                   [2:0] level, [3] busy, [4] timeout sticky, [31:16] serviced count
module devil_snoop_scheduler #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int FIFO_DEPTH         = 4,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          acvalid,
    output logic                          acready,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   acaddr,
    input  logic [3:0]                    acsnoop,
    output logic                          crvalid,
    input  logic                          crready,
    output logic [4:0]                    crresp,
    output logic                          eng_start,
    output logic [C_ACE_ADDR_WIDTH-1:0]   eng_acaddr,
    output logic [3:0]                    eng_acsnoop,
    input  logic                          eng_done,
    input  logic [4:0]                    eng_crresp,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_status_reg
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        SCH_IDLE     = 2'd0,
        SCH_DISPATCH = 2'd1,
        SCH_WAIT     = 2'd2,
        SCH_RESP     = 2'd3
    } sch_state_t;

    sch_state_t                  r_state;
    logic [C_ACE_ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [3:0]                  r_fifo_snoop [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [LVL_W-1:0]            r_level;
    logic                        r_crvalid;
    logic [4:0]                  r_crresp;
    logic                        r_eng_start;
    logic [C_ACE_ADDR_WIDTH-1:0] r_eng_acaddr;
    logic [3:0]                  r_eng_acsnoop;
    logic [15:0]                 r_serviced;
`ifdef DEVIL_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]            r_wait_cnt;
    logic                        r_timeout_sticky;
`endif

    logic       w_enable;
    logic       w_bypass;
    logic [4:0] w_dflt_resp;
    logic       w_push;
    logic       w_pop;
    logic       w_unused_ctrl;

    assign w_enable      = i_control_reg[0];
    assign w_bypass      = i_control_reg[1];
    assign w_dflt_resp   = i_control_reg[6:2];
    assign w_unused_ctrl = ^i_control_reg[C_S_AXI_DATA_WIDTH-1:7];

    // acready comes straight from the registered level so a full queue never takes a push,
    // even when the head is being popped in the same cycle.
    assign acready = (r_level < LVL_W'(FIFO_DEPTH));
    assign w_push  = acvalid && acready;
    assign w_pop   = r_crvalid && crready;

    assign crvalid     = r_crvalid;
    assign crresp      = r_crresp;
    assign eng_start   = r_eng_start;
    assign eng_acaddr  = r_eng_acaddr;
    assign eng_acsnoop = r_eng_acsnoop;

    // Queue storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge ace_aclk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= acaddr;
            r_fifo_snoop[r_wr_ptr] <= acsnoop;
        end
    end

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    // Scheduler: only the head entry is ever in flight, which gives in-order responses.
    // Path selection is sampled once in SCH_IDLE, so control changes never redirect an
    // in-flight snoop.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            r_state          <= SCH_IDLE;
            r_crvalid        <= 1'b0;
            r_crresp         <= '0;
            r_eng_start      <= 1'b0;
            r_eng_acaddr     <= '0;
            r_eng_acsnoop    <= '0;
            r_serviced       <= '0;
`ifdef DEVIL_SCHED_TIMEOUT_EN
            r_wait_cnt       <= '0;
            r_timeout_sticky <= 1'b0;
`endif
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                SCH_IDLE: begin
                    if (r_level != '0) begin
                        if (w_enable && !w_bypass) begin
                            r_state       <= SCH_DISPATCH;
                            r_eng_start   <= 1'b1;
                            r_eng_acaddr  <= r_fifo_addr[r_rd_ptr];
                            r_eng_acsnoop <= r_fifo_snoop[r_rd_ptr];
                        end else begin
                            r_state   <= SCH_RESP;
                            r_crvalid <= 1'b1;
                            r_crresp  <= w_dflt_resp;
                        end
                    end
                end
                SCH_DISPATCH: begin
                    r_state <= SCH_WAIT;
`ifdef DEVIL_SCHED_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                SCH_WAIT: begin
                    // eng_done is checked first so it wins over a coinciding timeout.
                    if (eng_done) begin
                        r_state   <= SCH_RESP;
                        r_crvalid <= 1'b1;
                        r_crresp  <= eng_crresp;
                    end
`ifdef DEVIL_SCHED_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state          <= SCH_RESP;
                        r_crvalid        <= 1'b1;
                        r_crresp         <= w_dflt_resp;
                        r_timeout_sticky <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                SCH_RESP: begin
                    if (crready) begin
                        r_state    <= SCH_IDLE;
                        r_crvalid  <= 1'b0;
                        r_serviced <= r_serviced + 16'd1;
                    end
                end
                default: r_state <= SCH_IDLE;
            endcase
`ifdef DEVIL_SCHED_TIMEOUT_EN
            if (!w_enable) r_timeout_sticky <= 1'b0;
`endif
        end
    end

    always_comb begin
        o_status_reg        = '0;
        o_status_reg[2:0]   = 3'(r_level);
        o_status_reg[3]     = (r_state != SCH_IDLE);
`ifdef DEVIL_SCHED_TIMEOUT_EN
        o_status_reg[4]     = r_timeout_sticky;
`endif
        o_status_reg[31:16] = r_serviced;
    end
endmodule

// File: tb/tb_devil_snoop_scheduler.sv
// tb/tb_devil_snoop_scheduler.sv - scoreboard bench for devil_snoop_scheduler
module tb_devil_snoop_scheduler;
    localparam int AW = 44;
    localparam int DW = 32;

    logic          ace_aclk = 1'b0;
    logic          ace_areset;
    logic          acvalid;
    logic          acready;
    logic [AW-1:0] acaddr;
    logic [3:0]    acsnoop;
    logic          crvalid;
    logic          crready;
    logic [4:0]    crresp;
    logic          eng_start;
    logic [AW-1:0] eng_acaddr;
    logic [3:0]    eng_acsnoop;
    logic          eng_done;
    logic [4:0]    eng_crresp;
    logic [DW-1:0] i_control_reg;
    logic [DW-1:0] o_status_reg;

    devil_snoop_scheduler #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_ACE_ADDR_WIDTH  (AW),
        .FIFO_DEPTH        (4),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .ace_aclk     (ace_aclk),
        .ace_areset   (ace_areset),
        .acvalid      (acvalid),
        .acready      (acready),
        .acaddr       (acaddr),
        .acsnoop      (acsnoop),
        .crvalid      (crvalid),
        .crready      (crready),
        .crresp       (crresp),
        .eng_start    (eng_start),
        .eng_acaddr   (eng_acaddr),
        .eng_acsnoop  (eng_acsnoop),
        .eng_done     (eng_done),
        .eng_crresp   (eng_crresp),
        .i_control_reg(i_control_reg),
        .o_status_reg (o_status_reg)
    );

    always #5 ace_aclk = ~ace_aclk;

    int cyc = 0;
    always @(posedge ace_aclk) cyc = cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] eng_model(input logic [AW-1:0] a, input logic [3:0] s);
        return a[4:0] ^ {s, 1'b1};
    endfunction

    logic [4:0]    exp_q  [$];
    logic [AW-1:0] addr_q [$];
    logic [4:0]    dflt;
    bit            exp_engine  = 0;
    bit            exp_timeout = 0;
    int            t_acc       = 0;
    int            t_start     = 0;
    int            n_start     = 0;
    int            n_resp      = 0;
    int            eng_lat     = 1;
    bit            eng_silent  = 0;

    // Response monitor: pops the scoreboard on each handshake and checks that a stalled
    // response does not change.
    bit         prev_hold = 0;
    logic [4:0] prev_resp = '0;
    always @(negedge ace_aclk) begin
        if (ace_areset) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("crvalid_hold", crvalid, 1'b1);
                check("crresp_stable", crresp, prev_resp);
            end
            if (crvalid && crready) begin
                if (exp_q.size() == 0) check("sb_unexpected_resp", 1, 0);
                else check("sb_crresp", crresp, exp_q.pop_front());
                n_resp++;
            end
            prev_hold = crvalid && !crready;
            prev_resp = crresp;
        end
    end

    // Engine model: answers each dispatch after eng_lat cycles unless silenced.
    initial begin
        logic [4:0] r;
        eng_done   = 1'b0;
        eng_crresp = '0;
        forever begin
            @(negedge ace_aclk);
            if (eng_start && !ace_areset) begin
                n_start++;
                t_start = cyc;
                if (addr_q.size() == 0) check("eng_unexpected_start", 1, 0);
                else check("eng_acaddr", eng_acaddr, addr_q.pop_front());
                if (!eng_silent) begin
                    r = eng_model(eng_acaddr, eng_acsnoop);
                    repeat (eng_lat) @(posedge ace_aclk);
                    #1;
                    eng_done   = 1'b1;
                    eng_crresp = r;
                    @(posedge ace_aclk);
                    #1;
                    eng_done   = 1'b0;
                end
            end
        end
    end

    task automatic set_ctrl(input bit e, input bit b, input logic [4:0] d);
        i_control_reg = {25'd0, d, b, e};
        dflt          = d;
        exp_engine    = e && !b;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [3:0] s, input int max_wait, output bit ok);
        ok      = 0;
        acaddr  = a;
        acsnoop = s;
        acvalid = 1'b1;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge ace_aclk);
            if (acready) begin
                ok    = 1;
                t_acc = cyc;
                if (exp_engine) begin
                    addr_q.push_back(a);
                    exp_q.push_back(exp_timeout ? dflt : eng_model(a, s));
                end else begin
                    exp_q.push_back(dflt);
                end
            end
            @(posedge ace_aclk);
            #1;
        end
        acvalid = 1'b0;
    endtask

    task automatic wait_crvalid(input int max_wait, output int at);
        at = -1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge ace_aclk);
            if (crvalid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic drain(input string tag, input int max_wait);
        for (int i = 0; i < max_wait; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge ace_aclk);
        end
        check({"drain_", tag}, exp_q.size(), 0);
        repeat (2) @(posedge ace_aclk);
        #1;
    endtask

    initial begin
        bit ok;
        int at;
        int s0;
        int r0;
        int n_cv;

        ace_areset = 1'b1;
        acvalid    = 1'b0;
        acaddr     = '0;
        acsnoop    = '0;
        crready    = 1'b1;
        set_ctrl(1'b0, 1'b0, 5'd0);

        // Reset values
        repeat (3) @(posedge ace_aclk);
        @(negedge ace_aclk);
        check("rst_acready", acready, 1'b1);
        check("rst_crvalid", crvalid, 1'b0);
        check("rst_crresp", crresp, 5'd0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_acaddr", eng_acaddr, '0);
        check("rst_status", o_status_reg, '0);
        @(posedge ace_aclk);
        #1;
        ace_areset = 1'b0;
        @(posedge ace_aclk);
        #1;

        // Bypass path: default response, 2-cycle latency, no dispatch
        set_ctrl(1'b1, 1'b1, 5'h05);
        s0 = n_start;
        send(44'h123, 4'h1, 10, ok);
        check("byp_accept", ok, 1'b1);
        wait_crvalid(20, at);
        check("byp_latency", at - t_acc, 2);
        check("byp_crresp", crresp, 5'h05);
        drain("bypass", 50);
        @(negedge ace_aclk);
        check("byp_no_eng_start", n_start - s0, 0);
        check("byp_count", o_status_reg[31:16], 16'd1);
        check("byp_idle_busy", o_status_reg[3], 1'b0);
        @(posedge ace_aclk);
        #1;

        // Engine path: 0x1000 answered 0x11 three cycles after eng_start
        set_ctrl(1'b1, 1'b0, 5'h1F);
        eng_lat = 3;
        s0 = n_start;
        send(44'h1000, 4'h8, 10, ok);
        check("eng_accept", ok, 1'b1);
        wait_crvalid(30, at);
        check("eng_crresp_0x11", crresp, 5'h11);
        check("eng_busy", o_status_reg[3], 1'b1);
        drain("engine", 50);
        check("eng_single_start", n_start - s0, 1);

        // Engine path minimum latency with eng_done right after eng_start
        eng_lat = 1;
        send(44'h2A0, 4'h3, 10, ok);
        wait_crvalid(30, at);
        check("eng_latency", at - t_acc, 4);
        drain("engine_lat", 50);

        // Backpressure: four accepted, fifth stalled, four ordered responses on release
        crready = 1'b0;
        r0 = n_resp;
        for (int i = 0; i < 5; i++) begin
            send(44'h100 + 44'(i * 16), 4'(i), (i < 4) ? 20 : 4, ok);
            check($sformatf("bp_accept_%0d", i), ok, (i < 4) ? 1'b1 : 1'b0);
        end
        @(negedge ace_aclk);
        check("bp_acready_full", acready, 1'b0);
        check("bp_level", o_status_reg[2:0], 3'd4);
        @(posedge ace_aclk);
        #1;
        crready = 1'b1;
        drain("backpressure", 200);
        check("bp_resp_count", n_resp - r0, 4);

`ifdef DEVIL_SCHED_TIMEOUT_EN
        // Timeout: silent engine gets default response 16 cycles after SCH_WAIT entry
        set_ctrl(1'b1, 1'b0, 5'h0C);
        eng_silent  = 1;
        exp_timeout = 1;
        send(44'h4440, 4'h2, 10, ok);
        exp_timeout = 0;
        wait_crvalid(60, at);
        check("to_latency", at - t_start, 17);
        check("to_crresp", crresp, 5'h0C);
        check("to_sticky_set", o_status_reg[4], 1'b1);
        drain("timeout", 50);
        eng_silent = 0;
        set_ctrl(1'b0, 1'b0, 5'h0C);
        @(posedge ace_aclk);
        #1;
        @(negedge ace_aclk);
        check("to_sticky_clear", o_status_reg[4], 1'b0);
        @(posedge ace_aclk);
        #1;
`else
        @(negedge ace_aclk);
        check("no_timeout_sticky", o_status_reg[4], 1'b0);
        @(posedge ace_aclk);
        #1;
`endif

        // Reset while in SCH_WAIT; the late eng_done must not produce a response
        set_ctrl(1'b1, 1'b0, 5'h09);
        eng_lat = 6;
        send(44'h3000, 4'h2, 10, ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ace_aclk);
            if (eng_start) begin
                ok = 1;
                break;
            end
        end
        check("rstw_dispatch_seen", ok, 1'b1);
        @(posedge ace_aclk);
        #1;
        ace_areset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(negedge ace_aclk);
        check("rstw_acready", acready, 1'b1);
        check("rstw_crvalid", crvalid, 1'b0);
        check("rstw_eng_start", eng_start, 1'b0);
        check("rstw_eng_acaddr", eng_acaddr, '0);
        check("rstw_eng_acsnoop", eng_acsnoop, 4'd0);
        check("rstw_status", o_status_reg, '0);
        @(posedge ace_aclk);
        #1;
        ace_areset = 1'b0;
        n_cv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ace_aclk);
            if (crvalid) n_cv++;
        end
        check("rstw_no_late_resp", n_cv, 0);
        eng_lat = 1;
        @(posedge ace_aclk);
        #1;

        // Serviced count wraps 0xFFFF -> 0x0000
        set_ctrl(1'b1, 1'b1, 5'h07);
        @(negedge ace_aclk);
        force dut.r_serviced = 16'hFFFF;
        @(negedge ace_aclk);
        release dut.r_serviced;
        @(negedge ace_aclk);
        check("wrap_preload", o_status_reg[31:16], 16'hFFFF);
        @(posedge ace_aclk);
        #1;
        send(44'h5550, 4'h5, 10, ok);
        drain("wrap", 50);
        @(negedge ace_aclk);
        check("wrap_count", o_status_reg[31:16], 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
